// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo controller: tx FSM encoding,
// the ASCII control bytes it cares about, and default sizing.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } tx_state_e;

    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int DEF_ADDR_W = 4;
    localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/uart_echo_ctrl_if.sv
// Byte-level parallel interface between the UART core (master) and its
// echo client (slave).
interface uart_echo_ctrl_if;

    logic       received;
    logic [7:0] rx_byte;
    logic       recv_error;
    logic       is_transmitting;
    logic       transmit;
    logic [7:0] tx_byte;

    modport master (
        output received,
        output rx_byte,
        output recv_error,
        output is_transmitting,
        input  transmit,
        input  tx_byte
    );

    modport slave (
        input  received,
        input  rx_byte,
        input  recv_error,
        input  is_transmitting,
        output transmit,
        output tx_byte
    );

endinterface

// File: rtl/uart_echo_ctrl_sync_fifo.sv
// Single-clock FIFO with an occupancy counter; the head word is captured
// into rd_data on each accepted read. A write into a full FIFO is accepted
// only when a read frees a slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [ADDR_W:0]  level
);

    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic [WIDTH-1:0]  rd_data_q, rd_data_d;
    logic              do_wr, do_rd;

    assign full    = (level_q == DEPTH);
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = rd_data_q;

    // Empty is the pre-edge value, so a write into an empty FIFO is never bypassed.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        rd_data_d = rd_data_q;
        if (do_wr) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_rd) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            rd_data_d = mem[rd_ptr_q];
        end
        case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rd_data_q <= rd_data_d;
        end
    end

    // NOTE: storage is not reset; the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Echo client for the UART parallel interface: buffers received bytes and
// replays them through the transmit handshake, optionally expanding CR to CR LF.
module uart_echo_ctrl
    import uart_echo_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter bit EXPAND_CRLF = 1'b1,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    uart_echo_ctrl_if.slave   uart,
    output logic [ADDR_W:0]   fifo_level,
    output logic [CNT_W-1:0]  overflow_cnt,
    output logic [CNT_W-1:0]  error_cnt,
    output logic              busy
);

    tx_state_e        state_q, state_d;
    logic             transmit_q, transmit_d;
    logic             lf_pending_q, lf_pending_d;
    logic [CNT_W-1:0] overflow_q, overflow_d;
    logic [CNT_W-1:0] error_q, error_d;
    logic             pop, drop, full, empty;
    logic [7:0]       head_byte;

    sync_fifo #(
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (uart.received),
        .wr_data (uart.rx_byte),
        .rd_en   (pop),
        .rd_data (head_byte),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    // A pop in the same cycle frees the slot, so only a stalled full FIFO drops.
    assign pop  = (state_q == S_IDLE) && !empty && !uart.is_transmitting;
    assign drop = uart.received && full && !pop;

    // The inserted LF never occupies a FIFO slot; it overrides the popped byte.
    assign uart.tx_byte  = lf_pending_q ? ASCII_LF : head_byte;
    assign uart.transmit = transmit_q;
    assign overflow_cnt  = overflow_q;
    assign error_cnt     = error_q;
    assign busy          = !empty || (state_q != S_IDLE);

    always_comb begin
        state_d      = state_q;
        transmit_d   = 1'b0;
        lf_pending_d = lf_pending_q;
        overflow_d   = overflow_q;
        error_d      = error_q;

        if (drop && (overflow_q != '1)) begin
            overflow_d = overflow_q + 1'b1;
        end
        if (uart.recv_error && (error_q != '1)) begin
            error_d = error_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    transmit_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (uart.is_transmitting) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!uart.is_transmitting) begin
                    if (EXPAND_CRLF && !lf_pending_q && (head_byte == ASCII_CR)) begin
                        lf_pending_d = 1'b1;
                        transmit_d   = 1'b1;
                        state_d      = S_START;
                    end else begin
                        lf_pending_d = 1'b0;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            transmit_q   <= 1'b0;
            lf_pending_q <= 1'b0;
            overflow_q   <= '0;
            error_q      <= '0;
        end else begin
            state_q      <= state_d;
            transmit_q   <= transmit_d;
            lf_pending_q <= lf_pending_d;
            overflow_q   <= overflow_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench: two controllers (CRLF expansion on and off) share one
// receive stream, each driven by a simple UART transmitter model.
module tb_uart_echo_ctrl;

    localparam int FRAME = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic received = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic recv_error = 1'b0;
    logic stall = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_echo_ctrl_if if_a ();
    uart_echo_ctrl_if if_b ();

    logic [4:0] level_a, level_b;
    logic [7:0] ovf_a, ovf_b, err_a, err_b;
    logic       busy_a, busy_b;

    uart_echo_ctrl #(.ADDR_W(4), .EXPAND_CRLF(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .uart(if_a), .fifo_level(level_a),
        .overflow_cnt(ovf_a), .error_cnt(err_a), .busy(busy_a)
    );

    uart_echo_ctrl #(.ADDR_W(4), .EXPAND_CRLF(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .uart(if_b), .fifo_level(level_b),
        .overflow_cnt(ovf_b), .error_cnt(err_b), .busy(busy_b)
    );

    assign if_a.received = received;
    assign if_a.rx_byte = rx_byte;
    assign if_a.recv_error = recv_error;
    assign if_b.received = received;
    assign if_b.rx_byte = rx_byte;
    assign if_b.recv_error = recv_error;

    // UART transmitter models: a frame holds is_transmitting high for FRAME cycles.
    logic uart_a_busy = 1'b0, uart_b_busy = 1'b0;
    int left_a = 0, left_b = 0;
    logic [7:0] frame_a = 8'h00, frame_b = 8'h00;
    logic [7:0] log_a[$], log_b[$];
    int pulses_a = 0, pulses_b = 0, viol_a = 0, viol_b = 0;

    assign if_a.is_transmitting = uart_a_busy | stall;
    assign if_b.is_transmitting = uart_b_busy | stall;

    always @(posedge clk) begin
        if (rst) begin
            uart_a_busy <= 1'b0;
            left_a <= 0;
        end else if (if_a.transmit) begin
            pulses_a <= pulses_a + 1;
            if (if_a.is_transmitting) begin
                viol_a <= viol_a + 1;
            end else begin
                log_a.push_back(if_a.tx_byte);
                frame_a <= if_a.tx_byte;
                uart_a_busy <= 1'b1;
                left_a <= FRAME;
            end
        end else if (uart_a_busy) begin
            if (if_a.tx_byte != frame_a) viol_a <= viol_a + 1;
            if (left_a == 1) uart_a_busy <= 1'b0;
            left_a <= left_a - 1;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            uart_b_busy <= 1'b0;
            left_b <= 0;
        end else if (if_b.transmit) begin
            pulses_b <= pulses_b + 1;
            if (if_b.is_transmitting) begin
                viol_b <= viol_b + 1;
            end else begin
                log_b.push_back(if_b.tx_byte);
                frame_b <= if_b.tx_byte;
                uart_b_busy <= 1'b1;
                left_b <= FRAME;
            end
        end else if (uart_b_busy) begin
            if (if_b.tx_byte != frame_b) viol_b <= viol_b + 1;
            if (left_b == 1) uart_b_busy <= 1'b0;
            left_b <= left_b - 1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        received = 1'b1;
        rx_byte = b;
        tick();
        received = 1'b0;
    endtask

    task automatic wait_idle();
        logic idle;
        idle = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            idle = !busy_a && !busy_b && !if_a.is_transmitting && !if_b.is_transmitting;
            if (idle) break;
            tick();
        end
        check("idle_reached", {31'd0, idle}, 32'd1);
    endtask

    // Higher-level view of A's output: the original bytes, with each inserted LF removed.
    logic [7:0] orig_q[$];
    int lf_bad;

    task automatic collect_a(input int base);
        orig_q.delete();
        lf_bad = 0;
        for (int i = base; i < log_a.size(); i++) begin
            orig_q.push_back(log_a[i]);
            if (log_a[i] == 8'h0D) begin
                if (i + 1 >= log_a.size() || log_a[i + 1] != 8'h0A) lf_bad++;
                i++;
            end
        end
    endtask

    typedef struct {
        logic [7:0] rx;
        int         n_a;
        logic [7:0] a_second;
        int         n_b;
    } vec_t;

    task automatic echo_vec(input vec_t v);
        int base_a, base_b, pa, pb;
        base_a = log_a.size();
        base_b = log_b.size();
        pa = pulses_a;
        pb = pulses_b;
        received = 1'b1;
        rx_byte = v.rx;
        tick();
        received = 1'b0;
        check("lat_no_early_tx", {31'd0, if_a.transmit}, 32'd0);
        tick();
        check("lat_tx_a", {31'd0, if_a.transmit}, 32'd1);
        check("lat_byte_a", {24'd0, if_a.tx_byte}, {24'd0, v.rx});
        check("lat_tx_b", {31'd0, if_b.transmit}, 32'd1);
        wait_idle();
        check("frames_a", log_a.size() - base_a, v.n_a);
        check("pulses_a", pulses_a - pa, v.n_a);
        check("first_a", {24'd0, log_a[base_a]}, {24'd0, v.rx});
        if (v.n_a == 2) check("second_a", {24'd0, log_a[base_a + 1]}, {24'd0, v.a_second});
        check("frames_b", log_b.size() - base_b, v.n_b);
        check("pulses_b", pulses_b - pb, v.n_b);
        check("first_b", {24'd0, log_b[base_b]}, {24'd0, v.rx});
        check("level_after", {27'd0, level_a}, 32'd0);
        check("busy_after", {31'd0, busy_a}, 32'd0);
    endtask

    vec_t vecs[4];
    logic [7:0] in_q[$];
    int base, exp_ov, nerr, bad, j, miss;

    initial begin
        vecs[0] = '{rx: 8'h41, n_a: 1, a_second: 8'h00, n_b: 1};
        vecs[1] = '{rx: 8'h0D, n_a: 2, a_second: 8'h0A, n_b: 1};
        vecs[2] = '{rx: 8'h0A, n_a: 1, a_second: 8'h00, n_b: 1};
        vecs[3] = '{rx: 8'hFF, n_a: 1, a_second: 8'h00, n_b: 1};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_transmit", {31'd0, if_a.transmit}, 32'd0);
        check("rst_tx_byte", {24'd0, if_a.tx_byte}, 32'd0);
        check("rst_level", {27'd0, level_a}, 32'd0);
        check("rst_overflow", {24'd0, ovf_a}, 32'd0);
        check("rst_error", {24'd0, err_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);

        for (int i = 0; i < 4; i++) echo_vec(vecs[i]);

        // Fill to 16 while the transmitter looks busy, drop one, then push on a pop.
        base = log_a.size();
        stall = 1'b1;
        for (int i = 0; i < 16; i++) send_byte(8'h20 + 8'(i));
        check("full_level", {27'd0, level_a}, 32'd16);
        send_byte(8'h66);
        exp_ov = 1;
        check("full_drop_level", {27'd0, level_a}, 32'd16);
        check("full_drop_ovf", {24'd0, ovf_a}, exp_ov);
        received = 1'b1;
        rx_byte = 8'h55;
        stall = 1'b0;
        tick();
        received = 1'b0;
        check("full_pushpop_level", {27'd0, level_a}, 32'd16);
        check("full_pushpop_ovf", {24'd0, ovf_a}, exp_ov);
        check("full_pushpop_tx", {31'd0, if_a.transmit}, 32'd1);
        check("full_pushpop_byte", {24'd0, if_a.tx_byte}, 32'h20);
        wait_idle();
        bad = 0;
        for (int i = 0; i < 16; i++) if (log_a[base + i] != 8'h20 + 8'(i)) bad++;
        check("full_order", bad, 0);
        check("full_count", log_a.size() - base, 17);
        check("full_last", {24'd0, log_a[base + 16]}, 32'h55);

        // Burst of 20 bytes spaced 2 cycles apart, far faster than a frame.
        base = log_a.size();
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i));
            tick();
        end
        wait_idle();
        collect_a(base);
        check("burst_lf_inserted", lf_bad, 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (i >= orig_q.size() || orig_q[i] != 8'(i)) bad++;
        for (int i = 1; i < orig_q.size(); i++) if (orig_q[i] <= orig_q[i - 1]) bad++;
        check("burst_order", bad, 0);
        exp_ov = exp_ov + 20 - orig_q.size();
        check("burst_ovf", {24'd0, ovf_a}, exp_ov);

        // Random bytes and error strobes; A's output must be an in-order subsequence.
        base = log_a.size();
        in_q.delete();
        nerr = 0;
        for (int i = 0; i < 60; i++) begin
            in_q.push_back(8'($urandom));
            send_byte(in_q[i]);
            repeat ($urandom_range(0, 30)) begin
                if ($urandom_range(0, 7) == 0) begin
                    recv_error = 1'b1;
                    nerr++;
                end
                tick();
                recv_error = 1'b0;
            end
        end
        wait_idle();
        collect_a(base);
        check("rand_lf_inserted", lf_bad, 0);
        j = 0;
        miss = 0;
        foreach (orig_q[k]) begin
            while (j < in_q.size() && in_q[j] != orig_q[k]) j++;
            if (j >= in_q.size()) miss++;
            else j++;
        end
        check("rand_subsequence", miss, 0);
        exp_ov = exp_ov + 60 - orig_q.size();
        check("rand_ovf", {24'd0, ovf_a}, exp_ov);
        check("rand_err", {24'd0, err_a}, nerr);

        // 300 error strobes saturate the counter and never touch the FIFO.
        base = log_a.size();
        j = pulses_a;
        for (int i = 0; i < 300; i++) begin
            recv_error = 1'b1;
            tick();
            recv_error = 1'b0;
            tick();
            if (i == 9) check("err_count_mid", {24'd0, err_a}, nerr + 10);
        end
        check("err_saturated", {24'd0, err_a}, 32'hFF);
        check("err_level", {27'd0, level_a}, 32'd0);
        check("err_no_tx", pulses_a - j, 0);

        // Reset while a frame is in flight with 5 bytes queued.
        for (int i = 0; i < 6; i++) send_byte(8'h30 + 8'(i));
        for (int i = 0; i < 50 && !if_a.is_transmitting; i++) tick();
        tick();
        tick();
        check("pre_rst_level", {27'd0, level_a}, 32'd5);
        rst = 1'b1;
        tick();
        check("mid_rst_transmit", {31'd0, if_a.transmit}, 32'd0);
        check("mid_rst_level", {27'd0, level_a}, 32'd0);
        check("mid_rst_ovf", {24'd0, ovf_a}, 32'd0);
        check("mid_rst_err", {24'd0, err_a}, 32'd0);
        check("mid_rst_busy", {31'd0, busy_a}, 32'd0);
        rst = 1'b0;
        tick();
        echo_vec('{rx: 8'h5A, n_a: 1, a_second: 8'h00, n_b: 1});

        check("viol_a", viol_a, 0);
        check("viol_b", viol_b, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
